regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 117 +++++++++++
 tb/tb_regfile_mp.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// regfile_mp: two write ports with write-to-read bypass, NUM_RD combinational read ports,
// and a sequential clear engine that zeroes one entry per cycle after reset or on request.
// Revision: 1.0
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
    localparam bit              HAS_ZERO = (ZERO_REG != 0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [ADDR_W-1:0]   clr_cnt_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic drop0;
    logic drop1;
    logic wr0;
    logic wr1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        busy        = (state == CLEAR);
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                if (clr_cnt == LAST) begin
                    state_nxt   = IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign drop0 = HAS_ZERO && (waddr0 == '0);
    assign drop1 = HAS_ZERO && (waddr1 == '0);
    assign wr0   = we0 && !drop0 && !busy;
    // Port 0 wins a same-address collision, so port 1 is suppressed outright.
    assign wr1   = we1 && !drop1 && !busy && !(we0 && (waddr0 == waddr1));

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (wr0) mem[waddr0] <= wdata0;
            if (wr1) mem[waddr1] <= wdata1;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] lane;

        assign ra = raddr[i*ADDR_W +: ADDR_W];

        always_comb begin
            lane = mem[ra];
            if (busy || !re[i]) begin
                lane = '0;
            end else if (HAS_ZERO && (ra == '0)) begin
                lane = '0;
            end else if (we0 && !drop0 && (waddr0 == ra)) begin
                lane = wdata0;
            end else if (we1 && !drop1 && (waddr1 == ra)) begin
                lane = wdata1;
            end
        end

        assign rdata[i*DATA_W +: DATA_W] = lane;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// tb_regfile_mp: directed and randomized checks of two regfile_mp instances
// (ZERO_REG=1 and ZERO_REG=0, four read ports) against an array-based model.
// Revision: 1.0
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             we0, we1, clr_req;
    logic [AW-1:0]    waddr0, waddr1;
    logic [DW-1:0]    wdata0, wdata1;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata_z, rdata_n;
    logic             busy_z, busy_n;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata_z),
        .clr_req(clr_req), .busy(busy_z)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_nz (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata_n),
        .clr_req(clr_req), .busy(busy_n)
    );

    int          checks = 0;
    int          errors = 0;
    logic [DW-1:0] mdl [2][DEPTH];
    int          clear_left = DEPTH;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Instance 0 has ZERO_REG=1, instance 1 has ZERO_REG=0.
    function automatic logic [DW-1:0] model_read(input int inst, input int ln);
        logic [AW-1:0] a;
        bit zr;
        zr = (inst == 0);
        a  = raddr[ln*AW +: AW];
        if (clear_left > 0 || !re[ln]) return '0;
        if (zr && a == 0) return '0;
        if (we0 && !(zr && waddr0 == 0) && waddr0 == a) return wdata0;
        if (we1 && !(zr && waddr1 == 0) && waddr1 == a) return wdata1;
        return mdl[inst][a];
    endfunction

    task automatic sample();
        @(negedge clk);
        check("busy_z", DW'(busy_z), DW'(clear_left > 0));
        check("busy_n", DW'(busy_n), DW'(clear_left > 0));
        for (int l = 0; l < NR; l++) begin
            check($sformatf("rd_z%0d", l), rdata_z[l*DW +: DW], model_read(0, l));
            check($sformatf("rd_n%0d", l), rdata_n[l*DW +: DW], model_read(1, l));
        end
    endtask

    task automatic commit();
        @(posedge clk);
        if (!rst) begin
            clear_left = DEPTH;
        end else if (clear_left > 0) begin
            for (int k = 0; k < 2; k++) mdl[k][DEPTH-clear_left] = '0;
            clear_left--;
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit zr;
                zr = (k == 0);
                if (we1 && !(zr && waddr1 == 0)) mdl[k][waddr1] = wdata1;
                if (we0 && !(zr && waddr0 == 0)) mdl[k][waddr0] = wdata0;
            end
            if (clr_req) clear_left = DEPTH;
        end
        #1;
    endtask

    task automatic cyc();
        sample();
        commit();
    endtask

    task automatic idle_inputs();
        we0 = 0; we1 = 0; clr_req = 0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        re = '0; raddr = '0;
    endtask

    task automatic set_rd(input int ln, input logic [AW-1:0] a);
        raddr[ln*AW +: AW] = a;
        re[ln] = 1'b1;
    endtask

    // Counts busy cycles until busy drops; optionally pokes a write to addr 5 mid-clear.
    task automatic count_clear(input string tag, input bit poke);
        int n;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            we0 = poke && (k == 20);
            waddr0 = 5'd5;
            wdata0 = 32'h12345678;
            re = 4'hF;
            raddr = NR*AW'($urandom);
            sample();
            if (!busy_z) break;
            n++;
            commit();
        end
        we0 = 0;
        commit();
        check(tag, DW'(n), DW'(DEPTH));
    endtask

    initial begin
        idle_inputs();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < DEPTH; a++) mdl[k][a] = '0;

        repeat (2) cyc();
        rst = 1'b1;
        count_clear("clr_len_rst", 1'b0);

        // Bypass then array read.
        idle_inputs();
        we0 = 1; waddr0 = 5'd3; wdata0 = 32'hDEADBEEF; set_rd(0, 5'd3);
        sample(); check("byp3", rdata_z[0 +: DW], 32'hDEADBEEF); commit();
        we0 = 0;
        sample(); check("arr3", rdata_z[0 +: DW], 32'hDEADBEEF); commit();

        // Same-address collision: port 0 wins.
        we0 = 1; waddr0 = 5'd7; wdata0 = 32'h11111111;
        we1 = 1; waddr1 = 5'd7; wdata1 = 32'h22222222;
        set_rd(0, 5'd7); set_rd(1, 5'd7);
        sample(); check("col_byp", rdata_z[DW +: DW], 32'h11111111); commit();
        we0 = 0; we1 = 0;
        sample(); check("col_arr", rdata_n[0 +: DW], 32'h11111111); commit();

        we0 = 1; we1 = 1; waddr1 = 5'd8; set_rd(1, 5'd8);
        sample(); check("two_byp", rdata_z[DW +: DW], 32'h22222222); commit();
        we0 = 0; we1 = 0;
        sample();
        check("two_arr0", rdata_z[0 +: DW], 32'h11111111);
        check("two_arr1", rdata_n[DW +: DW], 32'h22222222);
        commit();

        // Entry 0: dropped with ZERO_REG=1, ordinary with ZERO_REG=0.
        idle_inputs();
        we1 = 1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF; set_rd(0, 5'd0);
        sample();
        check("z0_same", rdata_z[0 +: DW], 32'h0);
        check("nz0_same", rdata_n[0 +: DW], 32'hFFFFFFFF);
        commit();
        we1 = 0;
        sample();
        check("z0_next", rdata_z[0 +: DW], 32'h0);
        check("nz0_next", rdata_n[0 +: DW], 32'hFFFFFFFF);
        commit();

        // Four lanes read four independent addresses.
        idle_inputs();
        we0 = 1; waddr0 = 5'd10; wdata0 = 32'hA0A0A0A0;
        we1 = 1; waddr1 = 5'd11; wdata1 = 32'hB1B1B1B1;
        cyc();
        waddr0 = 5'd12; wdata0 = 32'hC2C2C2C2;
        waddr1 = 5'd13; wdata1 = 32'hD3D3D3D3;
        cyc();
        we0 = 0; we1 = 0;
        set_rd(0, 5'd13); set_rd(1, 5'd10); set_rd(2, 5'd12); set_rd(3, 5'd11);
        sample();
        check("lane0", rdata_z[0*DW +: DW], 32'hD3D3D3D3);
        check("lane1", rdata_z[1*DW +: DW], 32'hA0A0A0A0);
        check("lane2", rdata_z[2*DW +: DW], 32'hC2C2C2C2);
        check("lane3", rdata_z[3*DW +: DW], 32'hB1B1B1B1);
        commit();

        // Fill, request a clear, poke a write mid-clear, then read everything back.
        idle_inputs();
        for (int a = 1; a < DEPTH; a += 2) begin
            we0 = 1; waddr0 = AW'(a); wdata0 = $urandom | 32'h1;
            we1 = (a + 1 < DEPTH); waddr1 = AW'(a + 1); wdata1 = $urandom | 32'h1;
            cyc();
        end
        idle_inputs();
        clr_req = 1;
        cyc();
        clr_req = 0;
        count_clear("clr_len_req", 1'b1);
        idle_inputs();
        for (int b = 0; b < DEPTH; b += 4) begin
            for (int l = 0; l < NR; l++) set_rd(l, AW'(b + l));
            sample();
            for (int l = 0; l < NR; l++) begin
                check($sformatf("post_clr_z%0d", b + l), rdata_z[l*DW +: DW], 32'h0);
                check($sformatf("post_clr_n%0d", b + l), rdata_n[l*DW +: DW], 32'h0);
            end
            commit();
        end

        // Reset in the middle of a clear restarts it.
        idle_inputs();
        clr_req = 1;
        cyc();
        clr_req = 0;
        repeat (10) cyc();
        rst = 1'b0;
        clear_left = DEPTH;
        cyc();
        rst = 1'b1;
        count_clear("clr_len_restart", 1'b0);

        // Randomized traffic with frequent address collisions and bypass hits.
        for (int k = 0; k < 1500; k++) begin
            we0 = 1'($urandom); we1 = 1'($urandom);
            waddr0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            waddr1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wdata0 = $urandom; wdata1 = $urandom;
            re = NR'($urandom);
            for (int l = 0; l < NR; l++) begin
                case ($urandom_range(0, 3))
                    0: raddr[l*AW +: AW] = waddr0;
                    1: raddr[l*AW +: AW] = waddr1;
                    2: raddr[l*AW +: AW] = AW'($urandom_range(0, 3));
                    default: raddr[l*AW +: AW] = AW'($urandom);
                endcase
            end
            clr_req = ($urandom_range(0, 99) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
